zoned_thermostat_ctrl: RTL and testbench
========================================

Name: zoned_thermostat_ctrl

Overview:
- Sequential successor to the single-zone combinational heater/aircon/fan thermostat.
- Serves ZONES zones that share one heat/cool plant.
- Adds compressor protection (minimum on-time and anti-short-cycle lockout), fan run-on after the plant stops, per-zone valve control and a saturating run counter.
- Sits between the zone temperature comparators and the plant/valve drivers.

Parameters:
- ZONES, 4: number of zones; width of the call and valve vectors.
- TIMER_W, 8: width of the on/lockout/run-on timers.
- MIN_ON, 4: minimum cycles the plant stays on per run; must be ≥ 1 and < 2^TIMER_W.
- MIN_OFF, 3: lockout cycles after each run; must be ≥ 1 and < 2^TIMER_W.
- FAN_RUNON, 2: fan cycles after the plant stops; 0 disables run-on; must be < 2^TIMER_W.
- CNT_W, 8: width of the run counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  synchronous active-low reset.
- mode  in  1  1 = heat, 0 = cool.
- too_cold  in  ZONES  per-zone "below setpoint".
- too_hot  in  ZONES  per-zone "above setpoint".
- fan_on  in  1  user fan request.
- heater  out  1  heater drive.
- aircon  out  1  air conditioner drive.
- fan  out  1  blower drive.
- zone_valve  out  ZONES  per-zone valve open.
- state  out  2  0 = IDLE, 1 = RUN, 2 = LOCKOUT.
- run_count  out  CNT_W  number of RUN entries, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Combinational terms:
  - calls = mode ? too_cold : too_hot.
  - demand = |calls.
- Registers: state, tmr (TIMER_W), runon (TIMER_W), run_mode, valve_q, run_count.
- Reset (resetn = 0 at an edge) clears everything:
  - state = IDLE, tmr = 0, runon = 0, run_mode = 0, valve_q = 0, run_count = 0.
  - heater = aircon = 0.
  - Reset during RUN or LOCKOUT is immediate: no lockout, no run-on afterwards.
- Outputs (decoded from registers; fan also includes the fan_on input combinationally):
  - heater = (state == RUN) & run_mode.
  - aircon = (state == RUN) & ~run_mode.
  - fan = fan_on | (state == RUN) | (runon != 0).
  - zone_valve = valve_q.
  - heater and aircon are never both 1.
- IDLE:
  - If demand, go to RUN next cycle; tmr = MIN_ON-1; run_mode = mode; run_count += 1, saturating at all-ones.
  - Latency: call sampled at edge N, so heater/aircon are high after edge N.
- RUN:
  - run_demand = demand & (mode == run_mode).
  - If tmr != 0: tmr decrements.
  - Else if !run_demand: go to LOCKOUT; tmr = MIN_OFF-1; runon = FAN_RUNON.
  - The plant is therefore on for at least MIN_ON cycles, and for as long as run_demand persists after that.
  - A mode flip during RUN does not switch equipment. It removes run_demand; the plant finishes the minimum on-time, then goes to LOCKOUT.
- LOCKOUT:
  - Plant off; calls are ignored.
  - If tmr == 0, go to IDLE; else tmr decrements.
  - Lasts exactly MIN_OFF cycles, followed by at least 1 IDLE cycle before the next RUN.
- runon: decrements while nonzero, in any state. It is loaded only on the RUN→LOCKOUT transition.
- valve_q next value:
  - If next state is RUN: calls when (run_demand or entering from IDLE) and calls != 0; otherwise hold the current value. This keeps valves open during the minimum-on hold and after a mode flip.
  - Otherwise: 0.
  - As a result, valves open and close on the same edge as the plant.
- run_count never wraps.

Test Plan:
- Reset, mode=1, too_cold=0001 for 1 cycle at edge N:
  - heater=1 for exactly 4 cycles from edge N, zone_valve=0001 throughout, aircon=0.
  - state 1→2 for 3 cycles→0; fan=1 for 4+2 cycles; run_count=1.
- mode=0, too_hot=0110 held for 10 cycles, then bit 2 drops for 3 cycles, then 0:
  - aircon on 13 cycles.
  - zone_valve=0110, then 0010 for 3 cycles, then 0.
  - Then LOCKOUT 3 cycles.
- too_cold=1111 reasserted throughout LOCKOUT:
  - heater stays 0 for all 3 lockout cycles plus 1 IDLE cycle, then RUN; run_count increments by 1.
- mode 1→0 at the 2nd RUN cycle with too_hot=0001:
  - heater completes 4 cycles and aircon stays 0 in that run; zone_valve holds the heat-call value.
  - Then LOCKOUT 3, IDLE 1, then aircon=1 with zone_valve=0001.
- fan_on=1 with no calls: fan=1, heater=aircon=0, zone_valve=0. resetn=0 in RUN cycle 2: next edge heater=0, state=0, fan=fan_on only (no run-on).
- CNT_W=2, six complete runs: run_count reads 1,2,3,3,3,3.

Source files
------------

// File: rtl/zoned_thermostat_ctrl.sv
// rtl/zoned_thermostat_ctrl.sv - multi-zone heat/cool plant sequencer with compressor protection
module zoned_thermostat_ctrl #(
  parameter int ZONES     = 4,
  parameter int TIMER_W   = 8,
  parameter int MIN_ON    = 4,
  parameter int MIN_OFF   = 3,
  parameter int FAN_RUNON = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mode,
  input  logic [ZONES-1:0] too_cold,
  input  logic [ZONES-1:0] too_hot,
  input  logic             fan_on,
  output logic             heater,
  output logic             aircon,
  output logic             fan,
  output logic [ZONES-1:0] zone_valve,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] run_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  // Timers count down to zero, so a load of N-1 yields an N-cycle interval.
  localparam logic [TIMER_W-1:0] ON_LOAD    = TIMER_W'(MIN_ON - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD   = TIMER_W'(MIN_OFF - 1);
  localparam logic [TIMER_W-1:0] RUNON_LOAD = TIMER_W'(FAN_RUNON);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] tmr_q, tmr_d;
  logic [TIMER_W-1:0] runon_q, runon_d;
  logic               run_mode_q, run_mode_d;
  logic [ZONES-1:0]   valve_q, valve_d;
  logic [CNT_W-1:0]   run_count_q, run_count_d;

  logic [ZONES-1:0]   calls;
  logic               demand;
  logic               run_demand;

  // Next-state logic: the plant latches its mode at RUN entry and only releases
  // after the minimum on-time once the call in that mode has gone away.
  always_comb begin
    calls       = mode ? too_cold : too_hot;
    demand      = |calls;
    run_demand  = demand & (mode == run_mode_q);
    state_d     = state_q;
    tmr_d       = tmr_q;
    runon_d     = (runon_q != '0) ? runon_q - TIMER_W'(1) : runon_q;
    run_mode_d  = run_mode_q;
    run_count_d = run_count_q;
    valve_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (demand) begin
          state_d    = ST_RUN;
          tmr_d      = ON_LOAD;
          run_mode_d = mode;
          if (run_count_q != '1) run_count_d = run_count_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TIMER_W'(1);
        end else if (!run_demand) begin
          state_d = ST_LOCK;
          tmr_d   = OFF_LOAD;
          runon_d = RUNON_LOAD;
        end
      end
      ST_LOCK: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - TIMER_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase

    // Valves track live calls while they are relevant to the running mode;
    // otherwise they hold so zones stay open through the minimum-on hold.
    if (state_d == ST_RUN) begin
      if ((run_demand || state_q == ST_IDLE) && calls != '0) valve_d = calls;
      else                                                  valve_d = valve_q;
    end
  end

  // State registers with synchronous active-low clear; reset drops the plant instantly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      runon_q     <= '0;
      run_mode_q  <= 1'b0;
      valve_q     <= '0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      runon_q     <= runon_d;
      run_mode_q  <= run_mode_d;
      valve_q     <= valve_d;
      run_count_q <= run_count_d;
    end
  end

  assign heater     = (state_q == ST_RUN) &  run_mode_q;
  assign aircon     = (state_q == ST_RUN) & ~run_mode_q;
  assign fan        = fan_on | (state_q == ST_RUN) | (runon_q != '0);
  assign zone_valve = valve_q;
  assign state      = state_q;
  assign run_count  = run_count_q;

endmodule

// File: tb/tb_zoned_thermostat_ctrl.sv
// tb/tb_zoned_thermostat_ctrl.sv - directed scoreboard bench for zoned_thermostat_ctrl
module tb_zoned_thermostat_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       mode;
  logic [3:0] too_cold;
  logic [3:0] too_hot;
  logic       fan_on;
  logic       heater, aircon, fan;
  logic [3:0] zone_valve;
  logic [1:0] state;
  logic [7:0] run_count;
  logic       heater2, aircon2, fan2;
  logic [3:0] zone_valve2;
  logic [1:0] state2;
  logic [1:0] run_count2;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       ht;
    logic       ac;
    logic       fn;
    logic [3:0] vl;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  zoned_thermostat_ctrl dut (
    .clk(clk), .resetn(resetn), .mode(mode), .too_cold(too_cold), .too_hot(too_hot),
    .fan_on(fan_on), .heater(heater), .aircon(aircon), .fan(fan),
    .zone_valve(zone_valve), .state(state), .run_count(run_count)
  );

  zoned_thermostat_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .mode(mode), .too_cold(too_cold), .too_hot(too_hot),
    .fan_on(fan_on), .heater(heater2), .aircon(aircon2), .fan(fan2),
    .zone_valve(zone_valve2), .state(state2), .run_count(run_count2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sat2(input logic [7:0] v);
    return (v > 8'd3) ? 8'd3 : v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL step=%0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic s(input logic rn, input logic m, input logic [3:0] c, input logic [3:0] h,
                   input logic fo, input logic [1:0] st, input logic ht, input logic ac,
                   input logic fn, input logic [3:0] vl, input logic [7:0] cnt);
    exp_t e;
    resetn   = rn;
    mode     = m;
    too_cold = c;
    too_hot  = h;
    fan_on   = fo;
    exp_q.push_back('{st: st, ht: ht, ac: ac, fn: fn, vl: vl, cnt: cnt});
    @(posedge clk);
    #1;
    step_no++;
    e = exp_q.pop_front();
    chk("state",      {6'd0, state},      {6'd0, e.st});
    chk("heater",     {7'd0, heater},     {7'd0, e.ht});
    chk("aircon",     {7'd0, aircon},     {7'd0, e.ac});
    chk("fan",        {7'd0, fan},        {7'd0, e.fn});
    chk("zone_valve", {4'd0, zone_valve}, {4'd0, e.vl});
    chk("run_count",  run_count,          e.cnt);
    chk("state_w2",   {6'd0, state2},     {6'd0, e.st});
    chk("run_count_w2", {6'd0, run_count2}, sat2(e.cnt));
  endtask

  initial begin
    // reset state
    s(0, 0, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 0);
    s(1, 0, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 0);

    // single heat call for one cycle: 4 RUN, 3 LOCKOUT, fan 4+2
    s(1, 1, 4'h1, 4'h0, 0,  1, 1, 0, 1, 4'h1, 1);
    for (int i = 0; i < 3; i++) s(1, 1, 4'h0, 4'h0, 0,  1, 1, 0, 1, 4'h1, 1);
    s(1, 1, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 1);
    s(1, 1, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 1);
    s(1, 1, 4'h0, 4'h0, 0,  2, 0, 0, 0, 4'h0, 1);
    s(1, 1, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 1);

    // cooling, two zones then one, 13 cycles of aircon
    for (int i = 0; i < 10; i++) s(1, 0, 4'h0, 4'h6, 0,  1, 0, 1, 1, 4'h6, 2);
    for (int i = 0; i < 3; i++)  s(1, 0, 4'h0, 4'h2, 0,  1, 0, 1, 1, 4'h2, 2);
    s(1, 0, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 2);

    // heat calls during lockout are ignored; one IDLE cycle before RUN
    s(1, 1, 4'hF, 4'h0, 0,  2, 0, 0, 1, 4'h0, 2);
    s(1, 1, 4'hF, 4'h0, 0,  2, 0, 0, 0, 4'h0, 2);
    s(1, 1, 4'hF, 4'h0, 0,  0, 0, 0, 0, 4'h0, 2);
    s(1, 1, 4'hF, 4'h0, 0,  1, 1, 0, 1, 4'hF, 3);

    // mode flip in RUN cycle 2: heat finishes min-on with held valves
    for (int i = 0; i < 3; i++) s(1, 0, 4'hF, 4'h1, 0,  1, 1, 0, 1, 4'hF, 3);
    s(1, 0, 4'hF, 4'h1, 0,  2, 0, 0, 1, 4'h0, 3);
    s(1, 0, 4'hF, 4'h1, 0,  2, 0, 0, 1, 4'h0, 3);
    s(1, 0, 4'hF, 4'h1, 0,  2, 0, 0, 0, 4'h0, 3);
    s(1, 0, 4'hF, 4'h1, 0,  0, 0, 0, 0, 4'h0, 3);
    s(1, 0, 4'hF, 4'h1, 0,  1, 0, 1, 1, 4'h1, 4);
    for (int i = 0; i < 3; i++) s(1, 0, 4'h0, 4'h0, 0,  1, 0, 1, 1, 4'h1, 4);
    s(1, 0, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 4);
    s(1, 0, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 4);
    s(1, 0, 4'h0, 4'h0, 0,  2, 0, 0, 0, 4'h0, 4);
    s(1, 0, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 4);

    // user fan with no calls, then reset mid-run drops everything with no run-on
    s(1, 1, 4'h0, 4'h0, 1,  0, 0, 0, 1, 4'h0, 4);
    s(1, 1, 4'h1, 4'h0, 1,  1, 1, 0, 1, 4'h1, 5);
    s(1, 1, 4'h1, 4'h0, 1,  1, 1, 0, 1, 4'h1, 5);
    s(0, 1, 4'h1, 4'h0, 1,  0, 0, 0, 1, 4'h0, 0);
    s(1, 1, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 0);

    // six complete runs: narrow counter saturates at 3, wide one keeps counting
    for (int r = 1; r <= 6; r++) begin
      s(1, 1, 4'h1, 4'h0, 0,  1, 1, 0, 1, 4'h1, 8'(r));
      for (int i = 0; i < 3; i++) s(1, 1, 4'h0, 4'h0, 0,  1, 1, 0, 1, 4'h1, 8'(r));
      s(1, 1, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 8'(r));
      s(1, 1, 4'h0, 4'h0, 0,  2, 0, 0, 1, 4'h0, 8'(r));
      s(1, 1, 4'h0, 4'h0, 0,  2, 0, 0, 0, 4'h0, 8'(r));
      s(1, 1, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0, 8'(r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
